hook_rope_ctrl: RTL and testbench
=================================

Name: hook_rope_ctrl

Overview:
- Frame-rate controller that sequences the Gold Miner hook rope and configures the line-drawing datapath every frame.
- Owns the swing angle, the extend/retract length and the grab state.
- Drives the line drawer's x1,y1,x2,y2, width and colour, keeping y2 >= y1 so the drawer's y-bound test always holds.
- Sits between the game-control logic (fire key, collision detector, scoring) and the rope line drawer.

Parameters:
- ANCHOR_X, 320, rope anchor x (pixels).
- ANCHOR_Y, 60, rope anchor y (pixels).
- MIN_LEN, 32, resting rope length.
- MAX_LEN, 400, maximum rope length.
- EXTEND_STEP, 4, length increment per frame while extending.
- RETRACT_STEP, 4, unloaded length decrement per frame.
- SWING_DIV, 2, frames per angle step while swinging (>=1).
- ROPE_WIDTH, 2, 5-bit thickness passed to the drawer.
- ROPE_COLOR, 8'h49, RRRGGGBB rope colour.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-clock pulse per VGA frame.
- fire  in  1  launch request, pulse or level.
- hit  in  1  hook tip touching an object (level, from collision logic).
- hitWeight  in  2  weight class of the touched object, sampled with hit.
- ropeX1, ropeY1, ropeX2, ropeY2  out  11 each  line endpoints to the drawer.
- ropeWidth  out  5  constant ROPE_WIDTH.
- ropeColor  out  8  constant ROPE_COLOR.
- hookState  out  2  SWING=0, EXTEND=1, RETRACT=2.
- loaded  out  1  an object is attached.
- collected  out  1  one-clock pulse when a loaded hook returns.
- collectedWeight  out  2  weight, valid with collected.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values (also applied on reset mid-operation in any state):
  - state SWING, angle 8, swing direction +1, len MIN_LEN, loaded 0, fire latch 0, collected 0, collectedWeight 0.
  - ropeX1=ANCHOR_X, ropeY1=ANCHOR_Y, ropeX2=ANCHOR_X, ropeY2=ANCHOR_Y+MIN_LEN.
- Fire latch: fire asserted in SWING sets the latch on any clock. fire in EXTEND or RETRACT is ignored and not latched. The latch clears on entry to EXTEND.
- All state, angle and len updates happen only on the clock where startOfFrame=1.
- SWING:
  - Angle index 0..16 ping-pongs: step every SWING_DIV frames; direction reverses on reaching 0 or 16, so 16 is followed by 15.
  - If the fire latch is set at the frame tick: go to EXTEND, freeze the angle, no angle step that frame.
- EXTEND:
  - hit=1 at the tick: loaded<=1, latch hitWeight, go to RETRACT, len unchanged.
  - Else if len+EXTEND_STEP >= MAX_LEN, or the next ropeX2 is outside 0..639, or the next ropeY2 > 479: clamp len (MAX_LEN, or current len for an off-screen exit), go to RETRACT unloaded.
  - Else len += EXTEND_STEP.
  - hit and the MAX condition on the same tick: hit wins (loaded).
- RETRACT:
  - Step = RETRACT_STEP >> weight (minimum 1) when loaded, else RETRACT_STEP.
  - If len <= MIN_LEN+step: len <= MIN_LEN, go to SWING with angle kept. If loaded, pulse collected for exactly one clock with collectedWeight, then clear loaded.
  - Else len -= step.
  - hit is ignored in RETRACT.
- Endpoint pipeline:
  - Tick clock T: state and len update.
  - T+1: register products len*dx and len*dy (len is 10 bits, dx/dy are 9-bit signed Q8).
  - T+2: ropeX2 = ANCHOR_X + (len*dx >>> 8), ropeY2 = ANCHOR_Y + (len*dy >> 8); these registers update.
  - ropeX2/ropeY2 are otherwise held stable for the whole frame (no tearing). ropeX1 and ropeY1 are constant.
- Direction LUT: angle (i-8)*10 degrees.
  - dx = round(256*sin), dy = round(256*cos).
  - i=8: (0,256). i=12: (165,196). i=16: (252,44). i=4: (-165,196). i=0: (-252,44).
  - dy is always > 0, so ropeY2 > ropeY1 always holds.
- Off-screen check uses the signed result before truncation to 11 bits.

Decomposition:
- Package hook_pkg:
  - hook_state_t enum (SWING, EXTEND, RETRACT).
  - ANGLE_MAX=16, ANGLE_CENTER=8.
  - SCREEN_W=640, SCREEN_H=480.
  - Q8 fraction width.
- Sub-module hook_dir_lut: combinational 17-entry angle -> (dx signed 9b, dy 9b) table.
- The FSM, length arithmetic and endpoint pipeline stay in hook_rope_ctrl.

Test Plan:
- Reset asserted 3 clocks mid-EXTEND (len 200) -> hookState=0, ropeX2=320, ropeY2=92 on the clock after reset deasserts; collected stays 0.
- SWING_DIV=1, 8 frames from reset -> angle 16, ropeX2=320+(32*252>>>8)=351, ropeY2=60+(32*44>>8)=65 at T+2; next frame angle 15.
- Fire at angle 8, hit=0 -> len 32->400 after 92 frames (clamped), RETRACT 92 frames back to 32, hookState=0, collected never pulses.
- Fire at angle 8, hit with hitWeight=2 when len=100 -> RETRACT step 1, 68 frames to MIN_LEN, collected high exactly 1 clock with collectedWeight=2, loaded then 0.
- hit asserted on the same tick len reaches MAX_LEN -> loaded=1, RETRACT; fire pulses during EXTEND/RETRACT -> no re-launch after returning to SWING.
- Single-clock fire pulse mid-frame in SWING -> EXTEND entered on the next startOfFrame; ropeX2/ropeY2 change only 2 clocks after each startOfFrame.

Source files
------------

// File: rtl/hook_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hook_pkg
//  Brief    : Shared types and geometry constants for the hook rope controller
//  Revision : 1.0  initial release
// ============================================================================
package hook_pkg;

    typedef enum logic [1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2
    } hook_state_t;

    localparam int ANGLE_MAX    = 16;
    localparam int ANGLE_CENTER = 8;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int Q8_FRAC      = 8;

    // Heavier loads slow the rope, but it must always make progress.
    function automatic logic [9:0] shr_min1(input logic [9:0] v, input logic [1:0] s);
        logic [9:0] r;
        r = v >> s;
        return (r == 10'd0) ? 10'd1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hook_dir_lut.sv
`default_nettype none
// ============================================================================
//  Module   : hook_dir_lut
//  Brief    : Angle index 0..16 -> Q8 unit direction (dx signed, dy positive)
//  Revision : 1.0  initial release
// ============================================================================
module hook_dir_lut (
    input  logic        [4:0] i_angle,
    output logic signed [8:0] o_dx,
    output logic        [8:0] o_dy
);

    logic [4:0] w_off;
    logic [8:0] w_sin;

    // Table is symmetric about the centre index; only |offset| is stored.
    always_comb begin
        w_off = (i_angle >= 5'd8) ? (i_angle - 5'd8) : (5'd8 - i_angle);
        case (w_off)
            5'd0:    begin w_sin = 9'd0;   o_dy = 9'd256; end
            5'd1:    begin w_sin = 9'd44;  o_dy = 9'd252; end
            5'd2:    begin w_sin = 9'd88;  o_dy = 9'd241; end
            5'd3:    begin w_sin = 9'd128; o_dy = 9'd222; end
            5'd4:    begin w_sin = 9'd165; o_dy = 9'd196; end
            5'd5:    begin w_sin = 9'd196; o_dy = 9'd165; end
            5'd6:    begin w_sin = 9'd222; o_dy = 9'd128; end
            5'd7:    begin w_sin = 9'd241; o_dy = 9'd88;  end
            5'd8:    begin w_sin = 9'd252; o_dy = 9'd44;  end
            default: begin w_sin = 9'd0;   o_dy = 9'd256; end
        endcase
        o_dx = (i_angle < 5'd8) ? -$signed(w_sin) : $signed(w_sin);
    end

endmodule
`default_nettype wire

// File: rtl/hook_rope_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hook_rope_ctrl
//  Brief    : Frame-rate swing/extend/retract sequencer driving the rope line
//  Revision : 1.0  initial release
// ============================================================================
module hook_rope_ctrl
    import hook_pkg::*;
#(
    parameter int         ANCHOR_X     = 320,
    parameter int         ANCHOR_Y     = 60,
    parameter int         MIN_LEN      = 32,
    parameter int         MAX_LEN      = 400,
    parameter int         EXTEND_STEP  = 4,
    parameter int         RETRACT_STEP = 4,
    parameter int         SWING_DIV    = 2,
    parameter logic [4:0] ROPE_WIDTH   = 5'd2,
    parameter logic [7:0] ROPE_COLOR   = 8'h49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic        hit,
    input  logic [1:0]  hitWeight,
    output logic [10:0] ropeX1,
    output logic [10:0] ropeY1,
    output logic [10:0] ropeX2,
    output logic [10:0] ropeY2,
    output logic [4:0]  ropeWidth,
    output logic [7:0]  ropeColor,
    output logic [1:0]  hookState,
    output logic        loaded,
    output logic        collected,
    output logic [1:0]  collectedWeight
);

    localparam logic [9:0]         C_MIN_LEN  = 10'(MIN_LEN);
    localparam logic [9:0]         C_MAX_LEN  = 10'(MAX_LEN);
    localparam logic [9:0]         C_EXT      = 10'(EXTEND_STEP);
    localparam logic [9:0]         C_RET      = 10'(RETRACT_STEP);
    localparam logic [7:0]         C_DIV_LAST = 8'(SWING_DIV - 1);
    localparam logic [4:0]         C_AMAX     = 5'(ANGLE_MAX);
    localparam logic [4:0]         C_ACENTER  = 5'(ANGLE_CENTER);
    localparam logic signed [20:0] C_AX       = 21'(ANCHOR_X);
    localparam logic signed [20:0] C_AY       = 21'(ANCHOR_Y);
    localparam logic signed [20:0] C_XMAX     = 21'(SCREEN_W - 1);
    localparam logic signed [20:0] C_YMAX     = 21'(SCREEN_H - 1);

    hook_state_t        r_state;
    logic        [4:0]  r_angle;
    logic               r_dir_up;
    logic        [7:0]  r_div;
    logic        [9:0]  r_len;
    logic               r_fire;
    logic               r_loaded;
    logic        [1:0]  r_weight;
    logic               r_collected;
    logic        [1:0]  r_coll_w;
    logic               r_sof_d1;
    logic               r_sof_d2;
    logic signed [20:0] r_px;
    logic        [20:0] r_py;
    logic        [10:0] r_x2;
    logic        [10:0] r_y2;

    logic signed [8:0]  w_dx;
    logic        [8:0]  w_dy;
    logic        [4:0]  w_angle_nxt;
    logic        [10:0] w_ext_sum;
    logic               w_at_max;
    logic        [9:0]  w_cand;
    logic signed [20:0] w_npx;
    logic        [20:0] w_npy;
    logic signed [20:0] w_nx;
    logic signed [20:0] w_ny;
    logic               w_offscreen;
    logic        [9:0]  w_rstep;
    logic               w_ret_done;

    hook_dir_lut u_lut (
        .i_angle (r_angle),
        .o_dx    (w_dx),
        .o_dy    (w_dy)
    );

    // Project the tip at the candidate length so an exit is caught before it happens.
    always_comb begin
        w_angle_nxt = r_dir_up ? (r_angle + 5'd1) : (r_angle - 5'd1);
        w_ext_sum   = {1'b0, r_len} + {1'b0, C_EXT};
        w_at_max    = (w_ext_sum >= {1'b0, C_MAX_LEN});
        w_cand      = w_at_max ? C_MAX_LEN : w_ext_sum[9:0];
        w_npx       = $signed({11'b0, w_cand}) * $signed({{12{w_dx[8]}}, w_dx});
        w_npy       = {11'b0, w_cand} * {12'b0, w_dy};
        w_nx        = C_AX + (w_npx >>> Q8_FRAC);
        w_ny        = C_AY + $signed(w_npy >> Q8_FRAC);
        w_offscreen = (w_nx < 21'sd0) || (w_nx > C_XMAX) || (w_ny > C_YMAX);
        w_rstep     = r_loaded ? shr_min1(C_RET, r_weight) : C_RET;
        w_ret_done  = ({1'b0, r_len} <= ({1'b0, C_MIN_LEN} + {1'b0, w_rstep}));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SWING;
            r_angle     <= C_ACENTER;
            r_dir_up    <= 1'b1;
            r_div       <= 8'd0;
            r_len       <= C_MIN_LEN;
            r_fire      <= 1'b0;
            r_loaded    <= 1'b0;
            r_weight    <= 2'd0;
            r_collected <= 1'b0;
            r_coll_w    <= 2'd0;
        end else begin
            r_collected <= 1'b0;
            if (fire && (r_state == SWING))
                r_fire <= 1'b1;
            if (startOfFrame) begin
                case (r_state)
                    SWING: begin
                        if (r_fire) begin
                            r_state <= EXTEND;
                            r_fire  <= 1'b0;
                        end else if (r_div == C_DIV_LAST) begin
                            r_div   <= 8'd0;
                            r_angle <= w_angle_nxt;
                            if (w_angle_nxt == C_AMAX)
                                r_dir_up <= 1'b0;
                            else if (w_angle_nxt == 5'd0)
                                r_dir_up <= 1'b1;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    EXTEND: begin
                        if (hit) begin
                            r_loaded <= 1'b1;
                            r_weight <= hitWeight;
                            r_state  <= RETRACT;
                        end else if (w_offscreen) begin
                            r_state <= RETRACT;
                        end else if (w_at_max) begin
                            r_len   <= C_MAX_LEN;
                            r_state <= RETRACT;
                        end else begin
                            r_len <= w_cand;
                        end
                    end
                    RETRACT: begin
                        if (w_ret_done) begin
                            r_len   <= C_MIN_LEN;
                            r_state <= SWING;
                            if (r_loaded) begin
                                r_collected <= 1'b1;
                                r_coll_w    <= r_weight;
                                r_loaded    <= 1'b0;
                            end
                        end else begin
                            r_len <= r_len - w_rstep;
                        end
                    end
                    default: r_state <= SWING;
                endcase
            end
        end
    end

    // Endpoints move only two clocks after the tick and then hold for the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sof_d1 <= 1'b0;
            r_sof_d2 <= 1'b0;
            r_px     <= 21'sd0;
            r_py     <= 21'd0;
            r_x2     <= 11'(ANCHOR_X);
            r_y2     <= 11'(ANCHOR_Y + MIN_LEN);
        end else begin
            r_sof_d1 <= startOfFrame;
            r_sof_d2 <= r_sof_d1;
            if (r_sof_d1) begin
                r_px <= $signed({11'b0, r_len}) * $signed({{12{w_dx[8]}}, w_dx});
                r_py <= {11'b0, r_len} * {12'b0, w_dy};
            end
            if (r_sof_d2) begin
                r_x2 <= 11'(C_AX + (r_px >>> Q8_FRAC));
                r_y2 <= 11'(C_AY + $signed(r_py >> Q8_FRAC));
            end
        end
    end

    assign ropeX1          = 11'(ANCHOR_X);
    assign ropeY1          = 11'(ANCHOR_Y);
    assign ropeX2          = r_x2;
    assign ropeY2          = r_y2;
    assign ropeWidth       = ROPE_WIDTH;
    assign ropeColor       = ROPE_COLOR;
    assign hookState       = r_state;
    assign loaded          = r_loaded;
    assign collected       = r_collected;
    assign collectedWeight = r_coll_w;

endmodule
`default_nettype wire

// File: tb/tb_hook_rope_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hook_rope_ctrl
//  Brief    : Directed self-checking bench for hook_rope_ctrl (SWING_DIV=1)
//  Revision : 1.0  initial release
// ============================================================================
module tb_hook_rope_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sof = 1'b0;
    logic        fire = 1'b0;
    logic        hit = 1'b0;
    logic [1:0]  hw = 2'd0;
    logic [10:0] x1, y1, x2, y2;
    logic [4:0]  width;
    logic [7:0]  color;
    logic [1:0]  state;
    logic        loaded, collected;
    logic [1:0]  cweight;

    int          checks = 0;
    int          errors = 0;
    int          coll_cnt = 0;
    logic [1:0]  coll_w = 2'd0;

    always #5 clk = ~clk;

    hook_rope_ctrl #(.SWING_DIV(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (sof),
        .fire            (fire),
        .hit             (hit),
        .hitWeight       (hw),
        .ropeX1          (x1),
        .ropeY1          (y1),
        .ropeX2          (x2),
        .ropeY2          (y2),
        .ropeWidth       (width),
        .ropeColor       (color),
        .hookState       (state),
        .loaded          (loaded),
        .collected       (collected),
        .collectedWeight (cweight)
    );

    always @(negedge clk) begin
        if (collected) begin
            coll_cnt = coll_cnt + 1;
            coll_w   = cweight;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic frame();
        @(negedge clk) sof = 1'b1;
        @(negedge clk) sof = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_fire();
        @(negedge clk) fire = 1'b1;
        @(negedge clk) fire = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (x1 !== 11'd320 || y1 !== 11'd60) begin errors++; $display("FAIL reset_p1 got %0d,%0d want 320,60", x1, y1); end
        checks++; if (x2 !== 11'd320 || y2 !== 11'd92) begin errors++; $display("FAIL reset_p2 got %0d,%0d want 320,92", x2, y2); end
        checks++; if (loaded !== 1'b0 || collected !== 1'b0 || cweight !== 2'd0) begin errors++; $display("FAIL reset_flags got %b%b%0d want 000", loaded, collected, cweight); end
        checks++; if (width !== 5'd2 || color !== 8'h49) begin errors++; $display("FAIL reset_style got %0d,%h want 2,49", width, color); end
    endtask

    task automatic test_reset_mid_extend();
        int c0;
        do_reset();
        pulse_fire();
        frame();
        repeat (42) frame();
        checks++; if (state !== 2'd1 || y2 !== 11'd260) begin errors++; $display("FAIL midext_pre got st=%0d y2=%0d want 1,260", state, y2); end
        c0 = coll_cnt;
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midext_state got %0d want 0", state); end
        checks++; if (x2 !== 11'd320 || y2 !== 11'd92) begin errors++; $display("FAIL midext_p2 got %0d,%0d want 320,92", x2, y2); end
        checks++; if (coll_cnt !== c0 || loaded !== 1'b0) begin errors++; $display("FAIL midext_coll got %0d,%b want %0d,0", coll_cnt, loaded, c0); end
    endtask

    task automatic test_swing();
        do_reset();
        frame();
        checks++; if (x2 !== 11'd325 || y2 !== 11'd91) begin errors++; $display("FAIL swing_a9 got %0d,%0d want 325,91", x2, y2); end
        repeat (7) frame();
        checks++; if (x2 !== 11'd351 || y2 !== 11'd65) begin errors++; $display("FAIL swing_a16 got %0d,%0d want 351,65", x2, y2); end
        frame();
        checks++; if (x2 !== 11'd350 || y2 !== 11'd71) begin errors++; $display("FAIL swing_a15 got %0d,%0d want 350,71", x2, y2); end
        repeat (15) frame();
        checks++; if (x2 !== 11'd288 || y2 !== 11'd65) begin errors++; $display("FAIL swing_a0 got %0d,%0d want 288,65", x2, y2); end
        frame();
        checks++; if (x2 !== 11'd289 || y2 !== 11'd71 || state !== 2'd0) begin errors++; $display("FAIL swing_a1 got %0d,%0d st=%0d want 289,71,0", x2, y2, state); end
    endtask

    task automatic test_extend_clamp();
        int c0;
        do_reset();
        c0 = coll_cnt;
        pulse_fire();
        frame();
        checks++; if (state !== 2'd1 || y2 !== 11'd92) begin errors++; $display("FAIL clamp_enter got st=%0d y2=%0d want 1,92", state, y2); end
        repeat (91) frame();
        checks++; if (state !== 2'd1 || y2 !== 11'd456) begin errors++; $display("FAIL clamp_396 got st=%0d y2=%0d want 1,456", state, y2); end
        frame();
        checks++; if (state !== 2'd2 || y2 !== 11'd460 || x2 !== 11'd320 || loaded !== 1'b0) begin errors++; $display("FAIL clamp_400 got st=%0d p2=%0d,%0d ld=%b want 2,320,460,0", state, x2, y2, loaded); end
        repeat (91) frame();
        checks++; if (state !== 2'd2 || y2 !== 11'd96) begin errors++; $display("FAIL clamp_ret36 got st=%0d y2=%0d want 2,96", state, y2); end
        frame();
        checks++; if (state !== 2'd0 || y2 !== 11'd92) begin errors++; $display("FAIL clamp_home got st=%0d y2=%0d want 0,92", state, y2); end
        checks++; if (coll_cnt !== c0) begin errors++; $display("FAIL clamp_nocoll got %0d want %0d", coll_cnt, c0); end
    endtask

    task automatic test_hit_weight();
        int c0;
        do_reset();
        c0 = coll_cnt;
        pulse_fire();
        frame();
        repeat (17) frame();
        checks++; if (state !== 2'd1 || y2 !== 11'd160) begin errors++; $display("FAIL hitw_len100 got st=%0d y2=%0d want 1,160", state, y2); end
        hit = 1'b1; hw = 2'd2;
        frame();
        hit = 1'b0; hw = 2'd0;
        checks++; if (state !== 2'd2 || loaded !== 1'b1 || y2 !== 11'd160) begin errors++; $display("FAIL hitw_grab got st=%0d ld=%b y2=%0d want 2,1,160", state, loaded, y2); end
        repeat (67) frame();
        checks++; if (state !== 2'd2 || y2 !== 11'd93 || loaded !== 1'b1 || coll_cnt !== c0) begin errors++; $display("FAIL hitw_len33 got st=%0d y2=%0d ld=%b cc=%0d want 2,93,1,%0d", state, y2, loaded, coll_cnt, c0); end
        frame();
        checks++; if (state !== 2'd0 || loaded !== 1'b0 || y2 !== 11'd92) begin errors++; $display("FAIL hitw_home got st=%0d ld=%b y2=%0d want 0,0,92", state, loaded, y2); end
        checks++; if (coll_cnt !== c0 + 1 || coll_w !== 2'd2) begin errors++; $display("FAIL hitw_coll got cnt=%0d w=%0d want %0d,2", coll_cnt, coll_w, c0 + 1); end
    endtask

    task automatic test_hit_at_max();
        int c0;
        do_reset();
        c0 = coll_cnt;
        pulse_fire();
        frame();
        repeat (45) frame();
        pulse_fire();
        repeat (46) frame();
        checks++; if (state !== 2'd1 || y2 !== 11'd456) begin errors++; $display("FAIL hitmax_pre got st=%0d y2=%0d want 1,456", state, y2); end
        hit = 1'b1; hw = 2'd1;
        frame();
        hit = 1'b0; hw = 2'd0;
        checks++; if (state !== 2'd2 || loaded !== 1'b1 || y2 !== 11'd456) begin errors++; $display("FAIL hitmax_grab got st=%0d ld=%b y2=%0d want 2,1,456", state, loaded, y2); end
        pulse_fire();
        repeat (181) frame();
        checks++; if (state !== 2'd2 || y2 !== 11'd94) begin errors++; $display("FAIL hitmax_len34 got st=%0d y2=%0d want 2,94", state, y2); end
        frame();
        checks++; if (state !== 2'd0 || loaded !== 1'b0 || y2 !== 11'd92) begin errors++; $display("FAIL hitmax_home got st=%0d ld=%b y2=%0d want 0,0,92", state, loaded, y2); end
        checks++; if (coll_cnt !== c0 + 1 || coll_w !== 2'd1) begin errors++; $display("FAIL hitmax_coll got cnt=%0d w=%0d want %0d,1", coll_cnt, coll_w, c0 + 1); end
        repeat (3) frame();
        checks++; if (state !== 2'd0 || loaded !== 1'b0) begin errors++; $display("FAIL hitmax_norelaunch got st=%0d ld=%b want 0,0", state, loaded); end
    endtask

    task automatic test_mid_frame_fire();
        do_reset();
        frame();
        frame();
        checks++; if (x2 !== 11'd331 || y2 !== 11'd90) begin errors++; $display("FAIL mff_a10 got %0d,%0d want 331,90", x2, y2); end
        pulse_fire();
        repeat (2) @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mff_wait got st=%0d want 0", state); end
        @(negedge clk) sof = 1'b1;
        @(negedge clk) sof = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL mff_enter got st=%0d want 1", state); end
        repeat (3) @(negedge clk);
        @(negedge clk) sof = 1'b1;
        @(negedge clk) sof = 1'b0;
        checks++; if (x2 !== 11'd331 || y2 !== 11'd90) begin errors++; $display("FAIL mff_t0 got %0d,%0d want 331,90", x2, y2); end
        @(negedge clk);
        checks++; if (x2 !== 11'd331 || y2 !== 11'd90) begin errors++; $display("FAIL mff_t1 got %0d,%0d want 331,90", x2, y2); end
        @(negedge clk);
        checks++; if (x2 !== 11'd332 || y2 !== 11'd93) begin errors++; $display("FAIL mff_t2 got %0d,%0d want 332,93", x2, y2); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_extend();
        test_swing();
        test_extend_clamp();
        test_hit_weight();
        test_hit_at_max();
        test_mid_frame_fire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
